// File: rtl/square_shiftadd_pkg.sv
// Shared definitions for the fixed-point square / square-root blocks:
// FSM encoding, default operand width and Q-format fraction widths.
package square_shiftadd_pkg;

  localparam int unsigned DEF_IN_W   = 8;
  localparam int unsigned IN_FRAC_W  = 4;
  localparam int unsigned OUT_FRAC_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } sq_state_e;

  // Bits needed to hold a down-counter loaded with w.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/square_shiftadd_if.sv
// Request/result bundle for the shift-add squarer.
interface square_shiftadd_if #(
  parameter int unsigned IN_W = square_shiftadd_pkg::DEF_IN_W
) ();

  logic                start;
  logic [IN_W-1:0]     x_in;
  logic [2*IN_W-1:0]   sq_out;
  logic                done;
  logic                busy;

  modport master (
    output start, x_in,
    input  sq_out, done, busy
  );

  modport slave (
    input  start, x_in,
    output sq_out, done, busy
  );

endinterface

// File: rtl/square_shiftadd.sv
// Sequential unsigned squarer: one shift-add step per multiplier bit, LSB first,
// result Q(IN_W).(IN_W) from a Q(IN_W/2).(IN_W/2) operand.
module square_shiftadd
  import square_shiftadd_pkg::*;
#(
  parameter int unsigned IN_W = DEF_IN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  square_shiftadd_if.slave bus
);

  localparam int unsigned OUT_W = 2 * IN_W;
  localparam int unsigned CNT_W = cnt_width(IN_W);

  sq_state_e          state_q, state_d;
  logic [OUT_W-1:0]   mcand_q, mcand_d;
  logic [IN_W-1:0]    mplier_q, mplier_d;
  logic [OUT_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0]   sq_q, sq_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      sq_q     <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sq_q     <= sq_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  // Multiplicand is kept pre-shifted so step k adds (operand << k) directly.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sq_d     = sq_q;
    done_d   = 1'b0;
    busy_d   = busy_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          mcand_d  = OUT_W'(bus.x_in);
          mplier_d = bus.x_in;
          acc_d    = '0;
          cnt_d    = CNT_W'(IN_W);
          busy_d   = 1'b1;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        sq_d    = acc_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.sq_out = sq_q;
  assign bus.done   = done_q;
  assign bus.busy   = busy_q;

endmodule
